// File: rtl/lpc_decode.sv
// LPC synthesis decoder: rebuilds one frame of samples from a residue buffer
// and 10 Q15.16 predictor coefficients, one MAC per cycle.
module lpc_decode #(
    parameter int unsigned FRAME_LEN = 160,
    parameter int unsigned ORDER     = 10,
    parameter int unsigned COEF_FRAC = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               rready,
    output logic               busy,
    input  logic               residue_wen,
    input  logic [7:0]         residue_waddr,
    input  logic signed [15:0] residue_din,
    input  logic [9:0]         a_wsel,
    input  logic signed [31:0] a_din,
    input  logic [7:0]         y_raddr,
    output logic signed [15:0] y_dout
);

    localparam int unsigned NW = 8;
    localparam int unsigned KW = $clog2(ORDER + 1);
    localparam int unsigned HW = $clog2(ORDER);
    localparam int unsigned PW = 48;
    localparam int unsigned AW = 56;
    localparam logic signed [AW-1:0] RND  = AW'(1) << (COEF_FRAC - 1);
    localparam logic signed [AW-1:0] YMAX = AW'(32767);
    localparam logic signed [AW-1:0] YMIN = AW'(-32768);

    typedef enum logic [1:0] {IDLE, LOAD, MAC, WRITE} state_t;

    state_t state, state_nxt;

    logic signed [15:0] resid [FRAME_LEN];
    logic signed [31:0] coef  [ORDER];
    logic signed [15:0] ybuf  [FRAME_LEN];
    logic signed [15:0] hist  [ORDER];

    logic [NW-1:0]        n;
    logic [KW-1:0]        k;
    logic signed [AW-1:0] acc;
    logic signed [15:0]   e_cur;
    logic                 rready_q;

    logic idle, do_load, do_mac, do_write, last_sample;

    logic [NW:0]          tap;
    logic [HW-1:0]        hidx;
    logic signed [15:0]   y_tap;
    logic signed [31:0]   coef_tap;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] yfull;
    logic signed [15:0]   y_sat;

    assign last_sample = (n == NW'(FRAME_LEN - 1));

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = LOAD;
            LOAD:  state_nxt = MAC;
            MAC:   if (k == KW'(ORDER)) state_nxt = WRITE;
            WRITE: state_nxt = last_sample ? IDLE : LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idle     = (state == IDLE);
        do_load  = (state == LOAD);
        do_mac   = (state == MAC);
        do_write = (state == WRITE);
        busy     = !idle;
    end

    // Taps reaching before sample 0 come from the previous frame's tail.
    always_comb begin
        tap      = {1'b0, n} - (NW+1)'(k);
        hidx     = HW'(tap + (NW+1)'(ORDER));
        y_tap    = tap[NW] ? hist[hidx] : ybuf[tap[NW-1:0]];
        coef_tap = coef[HW'(k - KW'(1))];
        prod     = PW'(coef_tap) * PW'(y_tap);
    end

    always_comb begin
        yfull = ((acc + RND) >>> COEF_FRAC) + AW'(e_cur);
        if (yfull > YMAX)      y_sat = 16'sh7fff;
        else if (yfull < YMIN) y_sat = -16'sh8000;
        else                   y_sat = yfull[15:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FRAME_LEN; i++) begin
                resid[i] <= '0;
                ybuf[i]  <= '0;
            end
            for (int unsigned i = 0; i < ORDER; i++) begin
                coef[i] <= '0;
                hist[i] <= '0;
            end
            n        <= '0;
            k        <= '0;
            acc      <= '0;
            e_cur    <= '0;
            rready_q <= 1'b0;
        end else begin
            if (idle) begin
                if (residue_wen && (residue_waddr < NW'(FRAME_LEN)))
                    resid[residue_waddr] <= residue_din;
                for (int unsigned j = 0; j < ORDER; j++)
                    if (a_wsel[j]) coef[j] <= a_din;
                if (start) begin
                    n        <= '0;
                    rready_q <= 1'b0;
                end
            end
            if (do_load) begin
                e_cur <= resid[n];
                acc   <= '0;
                k     <= KW'(1);
            end
            if (do_mac) begin
                acc <= acc + AW'(prod);
                k   <= k + KW'(1);
            end
            if (do_write) begin
                ybuf[n] <= y_sat;
                if (last_sample) begin
                    for (int unsigned j = 0; j < ORDER - 1; j++)
                        hist[j] <= ybuf[FRAME_LEN - ORDER + j];
                    hist[ORDER-1] <= y_sat;
                    rready_q      <= 1'b1;
                end else begin
                    n <= n + NW'(1);
                end
            end
        end
    end

    assign rready = rready_q;
    assign y_dout = (y_raddr < NW'(FRAME_LEN)) ? ybuf[y_raddr] : '0;

endmodule

// File: tb/tb_lpc_decode.sv
// Self-checking bench for lpc_decode: directed frames plus randomized frames
// compared against a direct arithmetic evaluation of the synthesis filter.
module tb_lpc_decode;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               rready;
    logic               busy;
    logic               residue_wen;
    logic [7:0]         residue_waddr;
    logic signed [15:0] residue_din;
    logic [9:0]         a_wsel;
    logic signed [31:0] a_din;
    logic [7:0]         y_raddr;
    logic signed [15:0] y_dout;

    int checks = 0;
    int errors = 0;

    longint m_e [160];
    longint m_a [10];
    longint m_hist [10];
    longint m_y [160];
    longint m_next [160];

    lpc_decode #(.FRAME_LEN(160), .ORDER(10), .COEF_FRAC(16)) dut (
        .clk(clk), .reset(reset), .start(start), .rready(rready), .busy(busy),
        .residue_wen(residue_wen), .residue_waddr(residue_waddr),
        .residue_din(residue_din), .a_wsel(a_wsel), .a_din(a_din),
        .y_raddr(y_raddr), .y_dout(y_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_clear();
        foreach (m_e[i]) begin m_e[i] = 0; m_y[i] = 0; m_next[i] = 0; end
        foreach (m_a[i]) begin m_a[i] = 0; m_hist[i] = 0; end
    endtask

    // y[n] = sat16(e[n] + round(sum a_k*y[n-k])), history used for n-k<0.
    task automatic model_frame();
        for (int n = 0; n < 160; n++) begin
            longint p = 0;
            longint yv;
            for (int k = 1; k <= 10; k++) begin
                yv = (n - k >= 0) ? m_next[n-k] : m_hist[n-k+10];
                p += m_a[k-1] * yv;
            end
            m_next[n] = sat16(m_e[n] + ((p + 32768) >>> 16));
        end
    endtask

    task automatic model_commit();
        foreach (m_y[i]) m_y[i] = m_next[i];
        for (int j = 0; j < 10; j++) m_hist[j] = m_next[150+j];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
    endtask

    task automatic wr_e(input int addr, input int val);
        logic signed [15:0] v16;
        v16 = val[15:0];
        @(negedge clk);
        residue_wen = 1'b1;
        residue_waddr = addr[7:0];
        residue_din = v16;
        @(negedge clk);
        residue_wen = 1'b0;
        if (addr < 160) m_e[addr] = v16;
    endtask

    task automatic wr_a(input logic [9:0] sel, input logic signed [31:0] val);
        @(negedge clk);
        a_wsel = sel;
        a_din = val;
        @(negedge clk);
        a_wsel = '0;
        for (int j = 0; j < 10; j++) if (sel[j]) m_a[j] = val;
    endtask

    task automatic read_y(input int addr, output logic signed [15:0] v);
        @(negedge clk);
        y_raddr = addr[7:0];
        #1;
        v = y_dout;
    endtask

    task automatic run_frame(input bit inject);
        int cyc;
        int busy_cnt;
        logic signed [15:0] v;
        model_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        busy_cnt = 0;
        check("busy_after_start", busy, 1);
        check("rready_cleared", rready, 0);
        while (!rready && cyc < 2500) begin
            if (busy) busy_cnt++;
            if (inject && cyc == 300) begin
                start = 1'b1;
                residue_wen = 1'b1;
                residue_waddr = 8'd5;
                residue_din = 16'($urandom);
                a_wsel = '1;
                a_din = 32'($urandom);
            end
            if (inject && cyc == 301) begin
                start = 1'b0;
                residue_wen = 1'b0;
                a_wsel = '0;
            end
            if (cyc == 600) begin
                y_raddr = 8'd10;
                #1 check("mid_frame_new", y_dout, m_next[10]);
                y_raddr = 8'd120;
                #1 check("mid_frame_old", y_dout, m_y[120]);
            end
            @(negedge clk);
            cyc++;
        end
        check("rready_latency", cyc, 1921);
        check("busy_cycles", busy_cnt, 1920);
        check("busy_done", busy, 0);
        model_commit();
        for (int a = 0; a < 160; a++) begin
            read_y(a, v);
            check($sformatf("y[%0d]", a), v, m_y[a]);
        end
        for (int i = 0; i < 3; i++) begin
            read_y($urandom_range(160, 255), v);
            check("y_out_of_range", v, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        logic signed [15:0] v;
        for (int a = 0; a < 256; a++) begin
            read_y(a, v);
            check(tag, v, 0);
        end
    endtask

    initial begin
        logic signed [15:0] v;
        reset = 1'b0;
        start = 1'b0;
        residue_wen = 1'b0;
        residue_waddr = '0;
        residue_din = '0;
        a_wsel = '0;
        a_din = '0;
        y_raddr = '0;

        do_reset();
        check("reset_busy", busy, 0);
        check("reset_rready", rready, 0);
        check_all_zero("reset_y_zero");

        // Pass-through: zero predictor, e[n]=n.
        for (int n = 0; n < 160; n++) wr_e(n, n);
        run_frame(1'b0);
        read_y(0, v);   check("pass_y0", v, 0);
        read_y(159, v); check("pass_y159", v, 159);

        // Unit predictor holds the impulse, then carries it across frames.
        do_reset();
        wr_a(10'b1, 32'sh0001_0000);
        wr_e(0, 100);
        run_frame(1'b0);
        read_y(0, v);   check("hold_y0", v, 100);
        read_y(159, v); check("hold_y159", v, 100);
        wr_e(0, 0);
        run_frame(1'b0);
        read_y(0, v);   check("carry_y0", v, 100);
        read_y(159, v); check("carry_y159", v, 100);

        // Integrator saturates.
        do_reset();
        wr_a(10'b1, 32'sh0001_0000);
        for (int n = 0; n < 160; n++) wr_e(n, 1000);
        run_frame(1'b0);
        read_y(31, v);  check("sat_y31", v, 32000);
        read_y(32, v);  check("sat_y32", v, 32767);
        read_y(159, v); check("sat_y159", v, 32767);

        // Half-gain rounding, positive and negative.
        do_reset();
        wr_a(10'b1, 32'sh0000_8000);
        wr_e(0, 3);
        run_frame(1'b0);
        read_y(1, v); check("round_y1", v, 2);
        read_y(2, v); check("round_y2", v, 1);
        read_y(3, v); check("round_y3", v, 1);
        do_reset();
        wr_a(10'b1, 32'sh0000_8000);
        wr_e(0, -3);
        run_frame(1'b0);
        read_y(1, v); check("round_neg_y1", v, -1);

        // Randomized coefficients (multi-bit selects) and residues.
        do_reset();
        for (int i = 0; i < 6; i++)
            wr_a(10'($urandom_range(1, 1023)), 32'($signed($urandom_range(0, 40000)) - 20000));
        for (int n = 0; n < 160; n++) wr_e(n, int'($urandom_range(0, 4000)) - 2000);
        for (int i = 0; i < 4; i++) wr_e($urandom_range(160, 255), int'($urandom_range(0, 65535)));
        run_frame(1'b0);
        for (int n = 0; n < 160; n++) wr_e(n, int'($urandom_range(0, 60000)) - 30000);
        wr_a(10'($urandom_range(1, 1023)), 32'($signed($urandom_range(0, 200000)) - 100000));
        run_frame(1'b1);

        // Reset mid-frame aborts and wipes everything.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (499) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_rready", rready, 0);
        check_all_zero("abort_y_zero");
        reset = 1'b1;
        model_clear();
        for (int n = 0; n < 160; n++) wr_e(n, int'($urandom_range(0, 2000)) - 1000);
        wr_a(10'b11, 32'sh0000_4000);
        run_frame(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpc_decode.md
LPC_DECODE -- requirements
Module: lpc_decode

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 160: samples per frame.
REQ-002 SHALL have parameter ORDER, default 10: predictor order, equal to the number of coefficient slots.
REQ-003 SHALL have parameter COEF_FRAC, default 16: fractional bits of the coefficients (signed Q15.16).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: single-cycle request to decode one frame.
REQ-007 SHALL have port rready, output, 1: frame output valid in the y buffer.
REQ-008 SHALL have port busy, output, 1: decode in progress.
REQ-009 SHALL have port residue_wen, input, 1: residue write enable.
REQ-010 SHALL have port residue_waddr, input, 8: residue write address.
REQ-011 SHALL have port residue_din, input, 16: residue sample, signed.
REQ-012 SHALL have port a_wsel, input, 10: one-hot coefficient write select (bit k-1 selects a_k).
REQ-013 SHALL have port a_din, input, 32: coefficient, signed Q15.16.
REQ-014 SHALL have port y_raddr, input, 8: output-sample read address.
REQ-015 SHALL have port y_dout, output, 16: signed reconstructed sample; asynchronous read.

Function
REQ-016 SHALL compute y[n] = sat16(e[n] + ((P[n] + 2^15) >>> 16)), where P[n] = sum over k=1..10 of a_k*y[n-k], for n = 0..159.
REQ-017 SHALL form each product as 48-bit signed and accumulate in a signed accumulator of at least 56 bits, with no intermediate truncation.
REQ-018 SHALL saturate sat16 to the range [-32768, 32767].
REQ-019 SHALL take y[n-k] for n-k<0 from a 10-entry history register holding the last 10 outputs of the previous frame; the history SHALL update at the end of each frame and persist across frames.
REQ-020 SHALL implement FSM states IDLE, LOAD, MAC, WRITE:
- IDLE -> LOAD on start.
- LOAD: 1 cycle; fetches e[n] and clears the accumulator.
- MAC: 10 cycles; one product per cycle, k = 1..10.
- WRITE: 1 cycle; stores y[n].
- WRITE -> LOAD while n<159.
- WRITE -> IDLE after n=159.
REQ-021 SHALL take 12 cycles per sample; busy SHALL be high for exactly 1920 cycles, starting the cycle after start is sampled.
REQ-022 SHALL clear rready the cycle after an accepted start, and set rready (busy cleared) on the cycle after the final WRITE.
REQ-023 SHALL ignore start while busy.
REQ-024 SHALL ignore residue and coefficient writes while busy; when idle, writes SHALL take effect the next cycle.
REQ-025 SHALL, when a_wsel has multiple bits set, write every selected coefficient.
REQ-026 SHALL ignore residue_waddr >= 160, and SHALL return y_dout = 0 for y_raddr >= 160.
REQ-027 SHALL keep y_dout readable at any time; entries not yet rewritten during a decode SHALL show the previous frame's values.

Reset
REQ-028 SHALL, on reset low at a clock edge, return the FSM to IDLE and drive rready=0 and busy=0.
REQ-029 SHALL, on reset, zero all residue, coefficient, y-buffer and history storage; y_dout SHALL read 0 at every address.
REQ-030 SHALL abort any frame in progress when reset is asserted mid-frame; after reset release no partial results SHALL remain.

Verification
REQ-031 Bench SHALL cover: all a_k=0, e[n]=n, start -> y[n]=n for n=0..159; rready rises 1921 cycles after the start edge.
REQ-032 Bench SHALL cover: a_1=0x00010000, others 0, e[0]=100, rest 0 -> y[n]=100 for all n.
REQ-033 Bench SHALL cover: then a second start with e all 0 and the same coefficients -> y[n]=100 for all n (history carried across frames).
REQ-034 Bench SHALL cover: a_1=1.0, e all 1000 -> y[31]=32000, y[32..159]=32767 (saturation).
REQ-035 Bench SHALL cover: a_1=0x00008000 (0.5), e[0]=3, rest 0 -> y[1]=2, y[2]=1, y[3]=1; and with e[0]=-3 -> y[1]=-1.
REQ-036 Bench SHALL cover: reset low at cycle 500 of a frame -> next cycle busy=0, rready=0, y_dout=0 at every address; and a start or write issued while busy has no effect on the current frame's y values.
